muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_if.sv | 33 +++
 rtl/muldiv_iter_divider.sv | 66 ++++++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared encodings for the HI/LO multiply/divide unit.
//   op_e    : operation codes presented on the op bus (6/7 are reserved)
//   state_e : control FSM states (IDLE -> CALC -> FIX -> IDLE)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// EX-stage request/response bundle between the pipeline (master) and the
// multiply/divide unit (slave).
//   flush, start, op, a, b : pipeline -> unit
//   busy, done, hi, lo     : unit -> pipeline
// -----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, start, op, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
// Unsigned restoring divider, one quotient bit per i_step.
//   clk, resetn : clock, asynchronous active-low reset
//   i_load      : capture dividend/divisor magnitudes, clear remainder
//   i_step      : perform one restoring-division iteration
//   i_dividend  : dividend magnitude
//   i_divisor   : divisor magnitude
//   o_quot      : quotient magnitude (valid after WIDTH steps)
//   o_rem       : remainder magnitude (valid after WIDTH steps)
// The quotient register starts holding the dividend; each step shifts its
// MSB into the partial remainder and shifts the new quotient bit in at LSB.
// A zero divisor always "fits", giving an all-ones quotient and a remainder
// equal to the dividend.
// -----------------------------------------------------------------------------
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;

    // Partial remainder after the shift is WIDTH+1 bits wide.
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_shift = {r_rem, r_quot[WIDTH-1]};
        w_fits  = (w_shift >= {1'b0, r_divisor});
        // When it fits, the true difference is below the divisor, so the
        // low WIDTH bits are exact.
        w_diff  = w_shift[WIDTH-1:0] - r_divisor;
    end

    // NOTE: every register, including the datapath, is cleared by the
    // asynchronous reset so no X ever reaches HI/LO after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
        end else if (i_step) begin
            r_rem  <= w_fits ? w_diff : w_shift[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_fits};
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle MIPS HI/LO multiply/divide unit holding the architectural
// HI and LO registers.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : muldiv_if slave (flush/start/op/a/b in, busy/done/hi/lo out)
// Timeline for an arithmetic op accepted at edge T: WIDTH shift-add or
// restoring-divide iterations at T+1..T+WIDTH, sign fix and HI/LO write at
// T+WIDTH+1, done pulses in the following cycle. MTHI/MTLO write in one edge
// without becoming busy.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     resetn,
    muldiv_if.slave  bus
);

    state_e             r_state;
    state_e             w_next_state;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_is_div;

    logic               w_accept;
    logic               w_arith;
    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // ---------------------------------------------------------------- decode
    always_comb begin
        // flush outranks start, including MTHI/MTLO.
        w_accept = (r_state == ST_IDLE) && bus.start && !bus.flush;
        w_arith  = (bus.op[2] == 1'b0);
        w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        w_neg_a  = w_signed && bus.a[WIDTH-1];
        w_neg_b  = w_signed && bus.b[WIDTH-1];
        w_mag_a  = w_neg_a ? (~bus.a + 1'b1) : bus.a;
        w_mag_b  = w_neg_b ? (~bus.b + 1'b1) : bus.b;
    end

    // --------------------------------------------------------- multiply step
    // Accumulator = {partial product high, remaining multiplier bits}; the
    // carry out of the add re-enters at the top on the right shift.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_acc_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};
    end

    // ------------------------------------------------------------- divider
    iter_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_accept && w_arith),
        .i_step     ((r_state == ST_CALC) && r_is_div),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // ------------------------------------------------------------ sign fix
    // Remainder follows the dividend sign; product and quotient are negated
    // when the operand signs differ. Sign flags are zero for unsigned ops.
    always_comb begin
        w_prod_fix = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
        w_quot_fix = (r_sign_a ^ r_sign_b) ? (~w_quot + 1'b1) : w_quot;
        w_rem_fix  = r_sign_a ? (~w_rem + 1'b1) : w_rem;
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next state is assigned a default before the case so that no
    // path through this block can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_arith) w_next_state = ST_CALC;
            ST_CALC: begin
                if (bus.flush)          w_next_state = ST_IDLE;
                else if (r_cnt == 1'b1) w_next_state = ST_FIX;
            end
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees pre-edge values of the others.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX) && !bus.flush;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_mcand  <= w_mag_a;
                                r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                                r_sign_a <= w_neg_a;
                                r_sign_b <= w_neg_b;
                                r_is_div <= bus.op[1];
                                r_cnt    <= CNT_W'(WIDTH);
                            end
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (!r_is_div) r_acc <= w_acc_next;
                end
                ST_FIX: begin
                    if (!bus.flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
